// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, score ceiling and multiplier codes.
// Also holds the streak-to-multiplier mapping used by the score tracker.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam int MAX_SCORE = 99;

   localparam logic [1:0] MULT_1 = 2'd1;
   localparam logic [1:0] MULT_2 = 2'd2;
   localparam logic [1:0] MULT_3 = 2'd3;

   function automatic logic [1:0] mult_for_streak(
      input logic [2:0] streak,
      input logic [2:0] streak2,
      input logic [2:0] streak3
   );
      if (streak >= streak3) begin
         return MULT_3;
      end else if (streak >= streak2) begin
         return MULT_2;
      end
      return MULT_1;
   endfunction

endpackage

// File: rtl/score_tracker_edge_detect.sv
// Rising-edge pulse generator for a debounced button level.
// The history flop resets high so a button held through reset never produces a pulse.
module edge_detect
#(
   parameter logic RESET_VAL = 1'b1
)(
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic pulse
);

   logic level_q;
   logic level_d;

   always_comb begin
      level_d = level;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= RESET_VAL;
      end else begin
         level_q <= level_d;
      end
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/score_tracker.sv
// Per-game score, streak multiplier and lives tracker feeding the high-score stage.
// All outputs are registered; each reacts on the clock edge after the causing pulse.
module score_tracker
   import game_pkg::*;
#(
   parameter int BASE_POINTS = 4,
   parameter int MAX_SCORE   = game_pkg::MAX_SCORE,
   parameter int START_LIVES = 3,
   parameter int STREAK2     = 2,
   parameter int STREAK3     = 4
)(
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Start,
   input  logic       Defused,
   input  logic       Exploded,
   input  logic [3:0] TimeLeft,
   output logic [7:0] PlayerScore,
   output logic [1:0] Multiplier,
   output logic [2:0] Lives,
   output logic       Playing,
   output logic       GameOver
);

   state_t     state_q, state_d;
   logic [7:0] score_q, score_d;
   logic [1:0] mult_q, mult_d;
   logic [2:0] lives_q, lives_d;
   logic [2:0] streak_q, streak_d;
   logic       playing_q, playing_d;
   logic       game_over_q, game_over_d;
   logic       start_edge;
   logic [8:0] sum9;

   edge_detect #(
      .RESET_VAL (1'b1)
   ) u_start_edge (
      .clk   (Clk),
      .rst_n (Rst),
      .level (Start),
      .pulse (start_edge)
   );

   // Exploded takes priority over Defused; the 9-bit sum saturates before truncation.
   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      mult_d   = mult_q;
      lives_d  = lives_q;
      streak_d = streak_q;
      sum9     = 9'(score_q) + 9'(BASE_POINTS) + 9'(TimeLeft);

      case (state_q)
         IDLE, OVER: begin
            if (start_edge) begin
               state_d  = PLAY;
               lives_d  = 3'(START_LIVES);
               score_d  = 8'd0;
               streak_d = 3'd0;
               mult_d   = MULT_1;
            end
         end
         PLAY: begin
            if (Exploded) begin
               streak_d = 3'd0;
               mult_d   = MULT_1;
               lives_d  = lives_q - 3'd1;
               if (lives_q == 3'd1) begin
                  state_d = OVER;
               end
            end else if (Defused) begin
               if (sum9 > 9'(MAX_SCORE)) begin
                  score_d = 8'(MAX_SCORE);
               end else begin
                  score_d = sum9[7:0];
               end
               if (streak_q >= 3'(STREAK3)) begin
                  streak_d = 3'(STREAK3);
               end else begin
                  streak_d = streak_q + 3'd1;
               end
               mult_d = mult_for_streak(streak_d, 3'(STREAK2), 3'(STREAK3));
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      playing_d   = (state_d == PLAY);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= IDLE;
         score_q     <= 8'd0;
         mult_q      <= MULT_1;
         lives_q     <= 3'd0;
         streak_q    <= 3'd0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         mult_q      <= mult_d;
         lives_q     <= lives_d;
         streak_q    <= streak_d;
         playing_q   <= playing_d;
         game_over_q <= game_over_d;
      end
   end

   assign PlayerScore = score_q;
   assign Multiplier  = mult_q;
   assign Lives       = lives_q;
   assign Playing     = playing_q;
   assign GameOver    = game_over_q;

endmodule
